// File: rtl/match_sequencer.sv
// -----------------------------------------------------------------------------
// match_sequencer
//   Frame-level controller for one Pikachu Volleyball match. Generates the
//   frame tick, requests one physics step per frame, pulses the display latch
//   when physics results are ready, keeps score, runs the serve delay and hands
//   finished rallies to the replay unit through a request/busy handshake.
//
// Ports
//   clk            system clock (single domain)
//   reset          synchronous, active-high reset
//   start          one-cycle pulse, begins a match from IDLE or OVER
//   win_score      target points, sampled on start (0 is treated as 1)
//   replay_on      enables post-point replay, sampled in POINT
//   phys_valid     one-cycle pulse, physics step finished
//   phys_game_over ball landed this step (qualified by phys_valid)
//   phys_winner    1 = P1, 2 = P2 (qualified by phys_valid)
//   replay_busy    replay unit is playing back
//   frame_tick     one-cycle pulse per frame
//   phys_en        one-cycle physics step request
//   disp_latch     one-cycle pulse, copy physics positions to display
//   replay_req     level, held until replay_busy is seen or timeout
//   p1_score       running score of player 1
//   p2_score       running score of player 2
//   match_done     high in OVER
//   match_winner   0 until OVER, then 1 or 2
//   step_overrun   sticky, a frame tick arrived with a step outstanding
//   state          current FSM state encoding
// -----------------------------------------------------------------------------
module match_sequencer #(
    parameter int FRAME_DIV         = 1666666,
    parameter int SERVE_FRAMES      = 60,
    parameter int REPLAY_ACK_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] win_score,
    input  logic       replay_on,
    input  logic       phys_valid,
    input  logic       phys_game_over,
    input  logic [1:0] phys_winner,
    input  logic       replay_busy,
    output logic       frame_tick,
    output logic       phys_en,
    output logic       disp_latch,
    output logic       replay_req,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic       match_done,
    output logic [1:0] match_winner,
    output logic       step_overrun,
    output logic [2:0] state
);

    localparam int FC_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int SC_W = $clog2(SERVE_FRAMES + 2);
    localparam int AC_W = $clog2(REPLAY_ACK_FRAMES + 2);

    localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FRAME_DIV - 1);
    localparam logic [SC_W-1:0] SC_LOAD  = SC_W'(SERVE_FRAMES);
    localparam logic [AC_W-1:0] AC_LIMIT = AC_W'(REPLAY_ACK_FRAMES);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RALLY     = 3'd2,
        ST_STEP_WAIT = 3'd3,
        ST_POINT     = 3'd4,
        ST_REPLAY    = 3'd5,
        ST_OVER      = 3'd6
    } state_t;

    state_t          state_r;
    logic [FC_W-1:0] frame_cnt_r;
    logic [FC_W-1:0] frame_cnt_nxt_s;
    logic            frame_tick_r;
    logic            phys_en_r;
    logic            disp_latch_r;
    logic            replay_req_r;
    logic [3:0]      p1_r;
    logic [3:0]      p2_r;
    logic            match_done_r;
    logic [1:0]      match_winner_r;
    logic            step_overrun_r;
    logic            rearm_r;
    logic            step_pend_r;   // rearm step issued in SERVE, awaiting phys_valid
    logic            busy_seen_r;   // replay unit acknowledged the request
    logic [AC_W-1:0] ack_cnt_r;
    logic [SC_W-1:0] serve_cnt_r;
    logic [3:0]      tgt_r;

    // Score increment that holds at the 4-bit maximum.
    function automatic logic [3:0] sat_inc(input logic [3:0] s);
        return (s == 4'd15) ? s : s + 4'd1;
    endfunction

    // Next value of the free-running frame counter.
    always_comb begin
        if (frame_cnt_r == FC_LAST) begin
            frame_cnt_nxt_s = {FC_W{1'b0}};
        end else begin
            frame_cnt_nxt_s = frame_cnt_r + FC_W'(1);
        end
    end

    // Frame counter; the tick register is high while the count sits at its last value.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_r  <= {FC_W{1'b0}};
            frame_tick_r <= 1'b0;
        end else begin
            frame_cnt_r  <= frame_cnt_nxt_s;
            frame_tick_r <= (frame_cnt_nxt_s == FC_LAST);
        end
    end

    // Match FSM with all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            phys_en_r      <= 1'b0;
            disp_latch_r   <= 1'b0;
            replay_req_r   <= 1'b0;
            p1_r           <= 4'd0;
            p2_r           <= 4'd0;
            match_done_r   <= 1'b0;
            match_winner_r <= 2'd0;
            step_overrun_r <= 1'b0;
            rearm_r        <= 1'b0;
            step_pend_r    <= 1'b0;
            busy_seen_r    <= 1'b0;
            ack_cnt_r      <= {AC_W{1'b0}};
            serve_cnt_r    <= {SC_W{1'b0}};
            tgt_r          <= 4'd1;
        end else begin
            phys_en_r    <= 1'b0;
            disp_latch_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_OVER: begin
                    if (start) begin
                        tgt_r          <= (win_score == 4'd0) ? 4'd1 : win_score;
                        p1_r           <= 4'd0;
                        p2_r           <= 4'd0;
                        match_done_r   <= 1'b0;
                        match_winner_r <= 2'd0;
                        rearm_r        <= 1'b1;
                        step_pend_r    <= 1'b0;
                        serve_cnt_r    <= SC_LOAD;
                        state_r        <= ST_SERVE;
                    end
                end
                ST_SERVE: begin
                    if (step_pend_r) begin
                        // Reset step result: positions only, landing flag ignored.
                        if (phys_valid) begin
                            disp_latch_r <= 1'b1;
                            step_pend_r  <= 1'b0;
                        end
                    end else if (frame_tick_r) begin
                        if (rearm_r) begin
                            phys_en_r   <= 1'b1;
                            rearm_r     <= 1'b0;
                            step_pend_r <= 1'b1;
                        end else if (serve_cnt_r <= SC_W'(1)) begin
                            serve_cnt_r <= {SC_W{1'b0}};
                            state_r     <= ST_RALLY;
                        end else begin
                            serve_cnt_r <= serve_cnt_r - SC_W'(1);
                        end
                    end
                end
                ST_RALLY: begin
                    if (frame_tick_r) begin
                        phys_en_r <= 1'b1;
                        state_r   <= ST_STEP_WAIT;
                    end
                end
                ST_STEP_WAIT: begin
                    // A late step swallows the tick; it is flagged, not queued.
                    if (frame_tick_r) begin
                        step_overrun_r <= 1'b1;
                    end
                    if (phys_valid) begin
                        disp_latch_r <= 1'b1;
                        if (phys_game_over) begin
                            case (phys_winner)
                                2'd1: begin
                                    p1_r    <= sat_inc(p1_r);
                                    state_r <= ST_POINT;
                                end
                                2'd2: begin
                                    p2_r    <= sat_inc(p2_r);
                                    state_r <= ST_POINT;
                                end
                                default: begin
                                    rearm_r     <= 1'b1;
                                    serve_cnt_r <= SC_LOAD;
                                    state_r     <= ST_SERVE;
                                end
                            endcase
                        end else begin
                            state_r <= ST_RALLY;
                        end
                    end
                end
                ST_POINT: begin
                    if (p1_r >= tgt_r) begin
                        match_winner_r <= 2'd1;
                        match_done_r   <= 1'b1;
                        state_r        <= ST_OVER;
                    end else if (p2_r >= tgt_r) begin
                        match_winner_r <= 2'd2;
                        match_done_r   <= 1'b1;
                        state_r        <= ST_OVER;
                    end else if (replay_on) begin
                        replay_req_r <= 1'b1;
                        busy_seen_r  <= 1'b0;
                        ack_cnt_r    <= {AC_W{1'b0}};
                        state_r      <= ST_REPLAY;
                    end else begin
                        rearm_r     <= 1'b1;
                        serve_cnt_r <= SC_LOAD;
                        state_r     <= ST_SERVE;
                    end
                end
                ST_REPLAY: begin
                    if (!busy_seen_r) begin
                        if (replay_busy) begin
                            busy_seen_r  <= 1'b1;
                            replay_req_r <= 1'b0;
                        end else if (frame_tick_r) begin
                            // Replay unit never answered: give up and serve.
                            if ((ack_cnt_r + AC_W'(1)) >= AC_LIMIT) begin
                                replay_req_r <= 1'b0;
                                rearm_r      <= 1'b1;
                                serve_cnt_r  <= SC_LOAD;
                                state_r      <= ST_SERVE;
                            end else begin
                                ack_cnt_r <= ack_cnt_r + AC_W'(1);
                            end
                        end
                    end else if (!replay_busy) begin
                        rearm_r     <= 1'b1;
                        serve_cnt_r <= SC_LOAD;
                        state_r     <= ST_SERVE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign frame_tick   = frame_tick_r;
    assign phys_en      = phys_en_r;
    assign disp_latch   = disp_latch_r;
    assign replay_req   = replay_req_r;
    assign p1_score     = p1_r;
    assign p2_score     = p2_r;
    assign match_done   = match_done_r;
    assign match_winner = match_winner_r;
    assign step_overrun = step_overrun_r;
    assign state        = state_r;

endmodule

// File: tb/tb_match_sequencer.sv
// -----------------------------------------------------------------------------
// tb_match_sequencer
//   Scoreboard bench for match_sequencer. The stimulus process queues physics
//   outcomes together with the display/score state expected when each result
//   is latched, and the state expected the cycle after each POINT. A physics
//   responder answers every phys_en from the outcome queue; a monitor pops and
//   compares whenever the DUT shows disp_latch or leaves POINT.
// -----------------------------------------------------------------------------
module tb_match_sequencer;

    localparam int FRAME_DIV         = 4;
    localparam int SERVE_FRAMES      = 2;
    localparam int REPLAY_ACK_FRAMES = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SERVE  = 3'd1;
    localparam logic [2:0] S_RALLY  = 3'd2;
    localparam logic [2:0] S_STEP   = 3'd3;
    localparam logic [2:0] S_POINT  = 3'd4;
    localparam logic [2:0] S_REPLAY = 3'd5;
    localparam logic [2:0] S_OVER   = 3'd6;

    logic       clk = 1'b0;
    logic       reset, start, replay_on, phys_valid, phys_game_over, replay_busy;
    logic [3:0] win_score;
    logic [1:0] phys_winner;
    logic       frame_tick, phys_en, disp_latch, replay_req, match_done, step_overrun;
    logic [3:0] p1_score, p2_score;
    logic [1:0] match_winner;
    logic [2:0] state;

    always #5 clk = ~clk;

    match_sequencer #(
        .FRAME_DIV(FRAME_DIV),
        .SERVE_FRAMES(SERVE_FRAMES),
        .REPLAY_ACK_FRAMES(REPLAY_ACK_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .win_score(win_score),
        .replay_on(replay_on), .phys_valid(phys_valid),
        .phys_game_over(phys_game_over), .phys_winner(phys_winner),
        .replay_busy(replay_busy), .frame_tick(frame_tick), .phys_en(phys_en),
        .disp_latch(disp_latch), .replay_req(replay_req), .p1_score(p1_score),
        .p2_score(p2_score), .match_done(match_done), .match_winner(match_winner),
        .step_overrun(step_overrun), .state(state)
    );

    typedef struct packed {
        logic       go;
        logic [1:0] winner;
        logic [3:0] delay;
    } outcome_t;

    outcome_t    out_q[$];
    logic [10:0] disp_q[$];   // {p1, p2, state} in the disp_latch cycle
    logic [6:0]  point_q[$];  // {state, match_done, match_winner, replay_req} after POINT

    int n_cmp = 0;
    int n_bad = 0;
    int n_ticks;
    int guard;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_step(input logic go, input logic [1:0] w, input logic [3:0] dly,
                             input logic [3:0] e1, input logic [3:0] e2, input logic [2:0] est);
        out_q.push_back('{go: go, winner: w, delay: dly});
        disp_q.push_back({e1, e2, est});
    endtask

    task automatic push_point(input logic [2:0] s, input logic d, input logic [1:0] w,
                              input logic r);
        point_q.push_back({s, d, w, r});
    endtask

    task automatic cyc1();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc1();
        start = 1'b0;
    endtask

    task automatic wait_state(input logic [2:0] s, input int bound, input string name);
        int i;
        i = 0;
        while (state !== s && i < bound) begin
            cyc1();
            i++;
        end
        chk(name, state, s);
    endtask

    task automatic wait_req(input logic v, input int bound, input string name);
        int i;
        i = 0;
        while (replay_req !== v && i < bound) begin
            cyc1();
            i++;
        end
        chk(name, replay_req, v);
    endtask

    task automatic wait_drain(input int bound, input string name);
        int i;
        i = 0;
        while ((out_q.size() + disp_q.size() + point_q.size()) != 0 && i < bound) begin
            cyc1();
            i++;
        end
        chk(name, out_q.size() + disp_q.size() + point_q.size(), 0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, S_IDLE);
        chk({tag, "_p1"}, p1_score, 4'd0);
        chk({tag, "_p2"}, p2_score, 4'd0);
        chk({tag, "_done"}, match_done, 1'b0);
        chk({tag, "_winner"}, match_winner, 2'd0);
        chk({tag, "_overrun"}, step_overrun, 1'b0);
        chk({tag, "_req"}, replay_req, 1'b0);
        chk({tag, "_phys_en"}, phys_en, 1'b0);
        chk({tag, "_disp"}, disp_latch, 1'b0);
        chk({tag, "_tick"}, frame_tick, 1'b0);
    endtask

    // Physics responder: each phys_en consumes one queued outcome.
    initial begin : physics
        outcome_t o;
        phys_valid     = 1'b0;
        phys_game_over = 1'b0;
        phys_winner    = 2'd0;
        forever begin
            cyc1();
            if (phys_en === 1'b1) begin
                if (out_q.size() == 0) begin
                    chk("unexpected_phys_en", phys_en, 1'b0);
                end else begin
                    o = out_q.pop_front();
                    repeat (int'(o.delay)) @(posedge clk);
                    #1;
                    phys_valid     = 1'b1;
                    phys_game_over = o.go;
                    phys_winner    = o.winner;
                    cyc1();
                    phys_valid     = 1'b0;
                    phys_game_over = 1'b0;
                    phys_winner    = 2'd0;
                end
            end
        end
    end

    // Monitor: scoreboard pops plus per-cycle protocol checks.
    initial begin : monitor
        logic        prev_tick;
        logic [2:0]  prev_state;
        logic        outstanding;
        int          last_tick;
        int          cyc;
        logic [10:0] ed;
        logic [6:0]  ep;
        prev_tick   = 1'b0;
        prev_state  = S_IDLE;
        outstanding = 1'b0;
        last_tick   = -1;
        cyc         = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset === 1'b1) begin
                last_tick   = -1;
                outstanding = 1'b0;
                prev_tick   = 1'b0;
                prev_state  = S_IDLE;
            end else begin
                if (frame_tick === 1'b1) begin
                    if (last_tick >= 0) chk("tick_period", cyc - last_tick, FRAME_DIV);
                    last_tick = cyc;
                end
                if (phys_en === 1'b1) begin
                    chk("phys_en_after_tick", prev_tick, 1'b1);
                    chk("one_step_outstanding", outstanding, 1'b0);
                    outstanding = 1'b1;
                end
                if (phys_valid === 1'b1) outstanding = 1'b0;
                if (disp_latch === 1'b1) begin
                    if (disp_q.size() == 0) begin
                        chk("unexpected_disp_latch", disp_latch, 1'b0);
                    end else begin
                        ed = disp_q.pop_front();
                        chk("disp_p1_p2_state", {p1_score, p2_score, state}, ed);
                    end
                end
                if (prev_state == S_POINT) begin
                    if (point_q.size() == 0) begin
                        chk("unexpected_point", prev_state, S_IDLE);
                    end else begin
                        ep = point_q.pop_front();
                        chk("after_point_state_done_winner_req",
                            {state, match_done, match_winner, replay_req}, ep);
                    end
                end
                chk("point_one_cycle", (prev_state == S_POINT) && (state == S_POINT), 1'b0);
                prev_tick  = frame_tick;
                prev_state = state;
            end
        end
    end

    // Stimulus.
    initial begin : stim
        reset       = 1'b1;
        start       = 1'b0;
        win_score   = 4'd0;
        replay_on   = 1'b0;
        replay_busy = 1'b0;
        repeat (3) cyc1();
        chk_reset_vals("rst");
        reset = 1'b0;
        repeat (2) cyc1();

        // Scoring to 3 without replay; first rearm step reports a landing that must be ignored.
        push_step(1'b1, 2'd2, 4'd2, 4'd0, 4'd0, S_SERVE);
        push_step(1'b1, 2'd1, 4'd2, 4'd1, 4'd0, S_POINT);
        push_point(S_SERVE, 1'b0, 2'd0, 1'b0);
        push_step(1'b0, 2'd0, 4'd2, 4'd1, 4'd0, S_SERVE);
        push_step(1'b0, 2'd0, 4'd2, 4'd1, 4'd0, S_RALLY);
        push_step(1'b1, 2'd1, 4'd2, 4'd2, 4'd0, S_POINT);
        push_point(S_SERVE, 1'b0, 2'd0, 1'b0);
        push_step(1'b0, 2'd0, 4'd2, 4'd2, 4'd0, S_SERVE);
        push_step(1'b1, 2'd1, 4'd2, 4'd3, 4'd0, S_POINT);
        push_point(S_OVER, 1'b1, 2'd1, 1'b0);
        win_score = 4'd3;
        replay_on = 1'b0;
        pulse_start();
        chk("start_to_serve", state, S_SERVE);
        guard = 0;
        while (disp_latch !== 1'b1 && guard < 40) begin
            cyc1();
            guard++;
        end
        chk("rearm_disp_latch", disp_latch, 1'b1);
        n_ticks = 0;
        guard   = 0;
        while (phys_en !== 1'b1 && guard < 40) begin
            if (frame_tick === 1'b1) n_ticks++;
            cyc1();
            guard++;
        end
        chk("serve_ticks_before_rally_step", n_ticks, 3);
        wait_state(S_OVER, 600, "reach_over_a");
        chk("a_p1", p1_score, 4'd3);
        chk("a_p2", p2_score, 4'd0);
        chk("a_done", match_done, 1'b1);
        chk("a_winner", match_winner, 2'd1);
        repeat (20) cyc1();
        chk("a_over_holds", state, S_OVER);
        chk("a_no_overrun", step_overrun, 1'b0);
        wait_drain(50, "a_drain");

        // Restart from OVER with replay handshake.
        push_step(1'b0, 2'd0, 4'd2, 4'd0, 4'd0, S_SERVE);
        push_step(1'b1, 2'd2, 4'd2, 4'd0, 4'd1, S_POINT);
        push_point(S_REPLAY, 1'b0, 2'd0, 1'b1);
        win_score = 4'd5;
        replay_on = 1'b1;
        pulse_start();
        chk("b_restart_p1", p1_score, 4'd0);
        chk("b_restart_done", match_done, 1'b0);
        chk("b_restart_winner", match_winner, 2'd0);
        wait_req(1'b1, 200, "b_replay_req_rise");
        repeat (2) cyc1();
        chk("b_req_held", replay_req, 1'b1);
        replay_busy = 1'b1;
        cyc1();
        chk("b_req_drop_after_busy", replay_req, 1'b0);
        chk("b_still_replay", state, S_REPLAY);
        repeat (9) cyc1();
        push_step(1'b0, 2'd0, 4'd2, 4'd0, 4'd1, S_SERVE);
        push_step(1'b1, 2'd0, 4'd2, 4'd0, 4'd1, S_SERVE);
        push_step(1'b0, 2'd0, 4'd2, 4'd0, 4'd1, S_SERVE);
        push_step(1'b0, 2'd0, 4'd6, 4'd0, 4'd1, S_RALLY);
        push_step(1'b1, 2'd1, 4'd2, 4'd1, 4'd1, S_POINT);
        push_point(S_REPLAY, 1'b0, 2'd0, 1'b1);
        push_step(1'b0, 2'd0, 4'd2, 4'd1, 4'd1, S_SERVE);
        replay_busy = 1'b0;
        chk("b_busy_falls_replay", state, S_REPLAY);
        cyc1();
        chk("b_serve_after_busy", state, S_SERVE);
        chk("b_p2_score", p2_score, 4'd1);

        // Winner-0 landing, overrun step, then replay timeout.
        wait_req(1'b1, 400, "c_replay_req_rise");
        chk("c_overrun_sticky", step_overrun, 1'b1);
        n_ticks = 0;
        guard   = 0;
        while (replay_req === 1'b1 && guard < 40) begin
            if (frame_tick === 1'b1) n_ticks++;
            cyc1();
            guard++;
        end
        chk("c_timeout_ticks", n_ticks, REPLAY_ACK_FRAMES);
        chk("c_timeout_to_serve", state, S_SERVE);
        wait_drain(100, "c_drain");
        chk("c_scores", {p1_score, p2_score}, {4'd1, 4'd1});

        // Reset in the middle of STEP_WAIT; the late phys_valid must be ignored.
        out_q.push_back('{go: 1'b1, winner: 2'd1, delay: 4'd2});
        wait_state(S_STEP, 200, "d_reach_step_wait");
        reset = 1'b1;
        cyc1();
        chk_reset_vals("midrst");
        reset = 1'b0;
        repeat (8) cyc1();
        chk("d_idle_after_late_valid", state, S_IDLE);
        chk("d_scores_after_late_valid", {p1_score, p2_score}, 8'd0);

        // Start and reset together: reset wins.
        start = 1'b1;
        reset = 1'b1;
        cyc1();
        start = 1'b0;
        reset = 1'b0;
        chk("reset_beats_start", state, S_IDLE);
        repeat (2) cyc1();

        // win_score 0 means the first point wins, ahead of replay.
        push_step(1'b0, 2'd0, 4'd2, 4'd0, 4'd0, S_SERVE);
        push_step(1'b1, 2'd1, 4'd2, 4'd1, 4'd0, S_POINT);
        push_point(S_OVER, 1'b1, 2'd1, 1'b0);
        win_score = 4'd0;
        replay_on = 1'b1;
        pulse_start();
        wait_state(S_OVER, 300, "e_reach_over");
        chk("e_p1", p1_score, 4'd1);
        chk("e_winner", match_winner, 2'd1);
        chk("e_no_replay", replay_req, 1'b0);
        repeat (20) cyc1();
        wait_drain(20, "e_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "time limit");
    end

endmodule
